// File: rtl/frame_arb_pkg.sv
// Shared constants and state type for the frame stream arbiter.
package frame_arb_pkg;
  localparam logic [7:0] HEADER_ID = 8'hAA;
  localparam logic [7:0] FOOTER_ID = 8'h55;

  typedef enum logic [1:0] {IDLE, PASS, DROP} arb_state_t;
endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: picks the first requester strictly after i_ptr, wrapping.
module rr_priority_encoder #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         i_req,
  input  logic [$clog2(N_CH)-1:0] i_ptr,
  output logic [N_CH-1:0]         o_grant,
  output logic [$clog2(N_CH)-1:0] o_idx,
  output logic                    o_valid
);
  localparam int unsigned IDX_W = $clog2(N_CH);

  // Scan from the farthest offset down so the nearest requester after i_ptr wins last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned off = N_CH; off >= 1; off--) begin
      if (i_req[(32'(i_ptr) + off) % N_CH]) begin
        o_grant                              = '0;
        o_grant[(32'(i_ptr) + off) % N_CH]   = 1'b1;
        o_idx                                = IDX_W'((32'(i_ptr) + off) % N_CH);
        o_valid                              = 1'b1;
      end
    end
  end
endmodule

// File: rtl/frame_stream_arbiter.sv
// Merges N_CH framed AXI-Stream sources onto one stream, round-robin per frame, with header
// validation and line-limit truncation. Optional FRAME_ARB_CH_TAG_EN tags headers with GRANT_ID.
module frame_stream_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       CLK,
  input  logic                       EXT_RESET,
  input  logic                       SET_CONFIG,
  input  logic [15:0]                MAX_TRIGGER_LENGTH,
  input  logic [N_CH*DATA_W-1:0]     S_AXIS_tdata,
  input  logic [N_CH*DATA_W/8-1:0]   S_AXIS_tkeep,
  input  logic [N_CH-1:0]            S_AXIS_tvalid,
  input  logic [N_CH-1:0]            S_AXIS_tlast,
  output logic [N_CH-1:0]            S_AXIS_tready,
  output logic [DATA_W-1:0]          M_AXIS_tdata,
  output logic [DATA_W/8-1:0]        M_AXIS_tkeep,
  output logic                       M_AXIS_tvalid,
  output logic                       M_AXIS_tlast,
  input  logic                       M_AXIS_tready,
  output logic [$clog2(N_CH)-1:0]    GRANT_ID,
  output logic                       BUSY,
  output logic [CNT_W-1:0]           DROP_COUNT
);
  localparam int unsigned IDX_W  = $clog2(N_CH);
  localparam int unsigned KEEP_W = DATA_W / 8;

  arb_state_t         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_grant;
  logic [15:0]        r_max_len;
  logic [15:0]        r_cur_max;
  logic [CNT_W-1:0]   r_line_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic [N_CH-1:0]    w_enc_grant;
  logic [IDX_W-1:0]   w_enc_idx;
  logic               w_enc_valid;
  logic [7:0]         w_head;
  logic [DATA_W-1:0]  w_sel_data;
  logic [KEEP_W-1:0]  w_sel_keep;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_at_limit;
  logic               w_acc;
  logic               w_drop_evt;

  rr_priority_encoder #(.N_CH(N_CH)) u_rr (
    .i_req   (S_AXIS_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_enc_grant),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_head = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (w_enc_grant[k]) w_head = w_head | S_AXIS_tdata[k*DATA_W + DATA_W - 8 +: 8];
    end
  end

  assign w_sel_data  = S_AXIS_tdata[int'(r_grant)*DATA_W +: DATA_W];
  assign w_sel_keep  = S_AXIS_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
  assign w_sel_valid = S_AXIS_tvalid[r_grant];
  assign w_sel_last  = S_AXIS_tlast[r_grant];
  // Header is line 0, so line max_len+1 is the last legal slot for the footer.
  assign w_at_limit  = (r_state == PASS) && (32'(r_line_cnt) == 32'(r_cur_max) + 32'd1);
  assign w_acc       = w_sel_valid && ((r_state == PASS) ? M_AXIS_tready : (r_state == DROP));

  always_comb begin
    S_AXIS_tready = '0;
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tlast  = 1'b0;
    M_AXIS_tdata  = w_sel_data;
    M_AXIS_tkeep  = w_sel_keep;
    case (r_state)
      PASS: begin
        S_AXIS_tready[r_grant] = M_AXIS_tready;
        M_AXIS_tvalid          = w_sel_valid;
        M_AXIS_tlast           = w_sel_last | w_at_limit;
`ifdef FRAME_ARB_CH_TAG_EN
        if (r_line_cnt == '0) M_AXIS_tdata[DATA_W-9 -: 8] = 8'(r_grant);
`endif
      end
      DROP:    S_AXIS_tready[r_grant] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_drop_evt = 1'b0;
    case (r_state)
      IDLE:    w_drop_evt = !SET_CONFIG && w_enc_valid && (w_head != HEADER_ID);
      PASS:    w_drop_evt = w_acc && !w_sel_last && w_at_limit;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (EXT_RESET) begin
      r_state    <= IDLE;
      r_rr_ptr   <= IDX_W'(N_CH - 1);
      r_grant    <= '0;
      r_max_len  <= 16'd16;
      r_cur_max  <= 16'd16;
      r_line_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (SET_CONFIG) r_max_len <= MAX_TRIGGER_LENGTH;
      if (w_drop_evt && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (!SET_CONFIG && w_enc_valid) begin
            r_grant    <= w_enc_idx;
            r_line_cnt <= '0;
            r_cur_max  <= r_max_len;
            r_state    <= (w_head == HEADER_ID) ? PASS : DROP;
          end
        end
        PASS: begin
          if (w_acc) begin
            r_line_cnt <= r_line_cnt + 1'b1;
            if (w_sel_last) begin
              r_state  <= IDLE;
              r_rr_ptr <= r_grant;
            end else if (w_at_limit) begin
              r_state <= DROP;
            end
          end
        end
        DROP: begin
          if (w_acc && w_sel_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_grant;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign GRANT_ID   = r_grant;
  assign BUSY       = (r_state != IDLE);
  assign DROP_COUNT = r_drop_cnt;
endmodule

// File: tb/tb_frame_stream_arbiter.sv
// Directed self-checking bench for frame_stream_arbiter (4 channels, 128-bit data).
module tb_frame_stream_arbiter;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned KW     = DATA_W / 8;
  localparam int unsigned BW     = KW + 1 + DATA_W;

  logic                     CLK = 1'b0;
  logic                     EXT_RESET = 1'b1;
  logic                     SET_CONFIG = 1'b0;
  logic [15:0]              MAX_TRIGGER_LENGTH = 16'd16;
  logic [N_CH*DATA_W-1:0]   S_AXIS_tdata = '0;
  logic [N_CH*KW-1:0]       S_AXIS_tkeep = '0;
  logic [N_CH-1:0]          S_AXIS_tvalid = '0;
  logic [N_CH-1:0]          S_AXIS_tlast = '0;
  logic [N_CH-1:0]          S_AXIS_tready;
  logic [DATA_W-1:0]        M_AXIS_tdata;
  logic [KW-1:0]            M_AXIS_tkeep;
  logic                     M_AXIS_tvalid;
  logic                     M_AXIS_tlast;
  logic                     M_AXIS_tready = 1'b1;
  logic [$clog2(N_CH)-1:0]  GRANT_ID;
  logic                     BUSY;
  logic [CNT_W-1:0]         DROP_COUNT;

  always #5 CLK = ~CLK;

  frame_stream_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .EXT_RESET(EXT_RESET), .SET_CONFIG(SET_CONFIG),
    .MAX_TRIGGER_LENGTH(MAX_TRIGGER_LENGTH),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tready(M_AXIS_tready),
    .GRANT_ID(GRANT_ID), .BUSY(BUSY), .DROP_COUNT(DROP_COUNT)
  );

  logic [BW-1:0] src_mem [N_CH][256];
  int unsigned   src_rd [N_CH];
  int unsigned   src_wr [N_CH];
  logic [BW-1:0] exp_q [$];
  int            checks = 0;
  int            failures = 0;
  bit            rand_rdy = 1'b0;
  bit            prev_stall = 1'b0;
  int unsigned   ch3_start;

  // beat = {tkeep, tlast, tdata}
  function automatic logic [BW-1:0] make_beat(int ch, int id, int nlines, logic [7:0] hdr, int line);
    logic [31:0] w;
    logic [7:0]  top;
    logic [KW-1:0] keep;
    logic        last;
    w    = 32'(ch*1000 + id*100 + line);
    keep = '1;
    last = 1'b0;
    if (line == 0) top = hdr;
    else if (line == nlines + 1) begin top = 8'h55; keep = 16'h0FFF; last = 1'b1; end
    else top = 8'h33;
    if (line == 0) make_beat = {keep, last, top, 8'h5A, 8'(ch), 8'(id), w, ~w, w ^ 32'hA5A5_5A5A};
    else           make_beat = {keep, last, top, 8'(ch), 8'(id), 8'(line), w, ~w, w ^ 32'hA5A5_5A5A};
  endfunction

  task automatic drive_src();
    logic [BW-1:0] b;
    for (int k = 0; k < N_CH; k++) begin
      if (src_rd[k] != src_wr[k]) begin
        b = src_mem[k][src_rd[k]];
        S_AXIS_tvalid[k] = 1'b1;
        S_AXIS_tlast[k]  = b[DATA_W];
        S_AXIS_tkeep[k*KW +: KW]         = b[BW-1 -: KW];
        S_AXIS_tdata[k*DATA_W +: DATA_W] = b[DATA_W-1:0];
      end else begin
        S_AXIS_tvalid[k] = 1'b0;
        S_AXIS_tlast[k]  = 1'b0;
      end
    end
  endtask

  task automatic load_frame(int ch, int id, int nlines, logic [7:0] hdr);
    for (int l = 0; l <= nlines + 1; l++) begin
      src_mem[ch][src_wr[ch]] = make_beat(ch, id, nlines, hdr, l);
      src_wr[ch]++;
    end
    drive_src();
  endtask

  // Expected output of a good-header frame under line limit lim.
  task automatic exp_frame(int ch, int id, int nlines, int lim);
    logic [BW-1:0] b;
    int stop;
    stop = (nlines > lim) ? lim + 1 : nlines + 1;
    for (int l = 0; l <= stop; l++) begin
      b = make_beat(ch, id, nlines, 8'hAA, l);
`ifdef FRAME_ARB_CH_TAG_EN
      if (l == 0) b[DATA_W-9 -: 8] = 8'(ch);
`endif
      if (l == stop) b[DATA_W] = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    logic [N_CH-1:0] acc;
    logic [BW-1:0]   got;
    @(negedge CLK);
    acc = S_AXIS_tvalid & S_AXIS_tready;
    if (prev_stall) chk("m_valid_held", 64'(M_AXIS_tvalid), 64'd1);
    if (M_AXIS_tvalid === 1'b1) begin
      got = {M_AXIS_tkeep, M_AXIS_tlast, M_AXIS_tdata};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL m_unexpected observed=%h expected=none", got);
      end else begin
        assert (got === exp_q[0]) else begin
          failures++;
          $error("FAIL m_beat observed=%h expected=%h", got, exp_q[0]);
        end
        if (M_AXIS_tready) void'(exp_q.pop_front());
      end
    end
    prev_stall = (M_AXIS_tvalid === 1'b1) && !M_AXIS_tready;
    @(posedge CLK);
    #1;
    for (int k = 0; k < N_CH; k++) if (acc[k]) src_rd[k]++;
    drive_src();
    M_AXIS_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && BUSY == 1'b0 &&
           src_rd[0] == src_wr[0] && src_rd[1] == src_wr[1] &&
           src_rd[2] == src_wr[2] && src_rd[3] == src_wr[3])) begin
      cycle();
      n++;
    end
    chk({tag, "_drain_timeout"}, 64'(n < budget), 64'd1);
    chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    EXT_RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_grant", 64'(GRANT_ID), 64'd0);
    chk("rst_drop", 64'(DROP_COUNT), 64'd0);
    chk("rst_s_ready", 64'(S_AXIS_tready), 64'd0);
    chk("rst_m_valid", 64'(M_AXIS_tvalid), 64'd0);
    chk("rst_m_last", 64'(M_AXIS_tlast), 64'd0);
    @(posedge CLK); #1;
    EXT_RESET = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) begin src_rd[k] = 0; src_wr[k] = 0; end

    // 1: ten frames on ch0, first one already valid during reset
    for (int f = 0; f < 10; f++) begin load_frame(0, f, 6, 8'hAA); exp_frame(0, f, 6, 16); end
    do_reset();
    drain("t1", 400);
    chk("t1_drop", 64'(DROP_COUNT), 64'd0);

    // 2: all four channels loaded at once, pointer back to N_CH-1 -> order 0,1,2,3,0,1,2,3
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) load_frame(c, 20 + f, 2 + c, 8'hAA);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) exp_frame(c, 20 + f, 2 + c, 16);
    drain("t2", 400);
    chk("t2_grant", 64'(GRANT_ID), 64'd3);

    // 3: bad header on ch1 is swallowed, ch2 good frame follows (pointer 3 -> ch1 then ch2)
    load_frame(1, 30, 4, 8'h11);
    load_frame(2, 31, 3, 8'hAA);
    exp_frame(2, 31, 3, 16);
    drain("t3", 200);
    chk("t3_drop", 64'(DROP_COUNT), 64'd1);
    chk("t3_ch1_consumed", 64'(src_rd[1]), 64'(src_wr[1]));

    // 4: line limit 4
    SET_CONFIG = 1'b1; MAX_TRIGGER_LENGTH = 16'd4;
    cycle();
    SET_CONFIG = 1'b0;
    load_frame(0, 40, 8, 8'hAA); exp_frame(0, 40, 8, 4);
    drain("t4a", 200);
    chk("t4a_drop", 64'(DROP_COUNT), 64'd2);
    load_frame(0, 41, 4, 8'hAA); exp_frame(0, 41, 4, 4);
    drain("t4b", 200);
    chk("t4b_drop", 64'(DROP_COUNT), 64'd2);
    load_frame(0, 42, 5, 8'hAA); exp_frame(0, 42, 5, 4);
    drain("t4c", 200);
    chk("t4c_drop", 64'(DROP_COUNT), 64'd3);
    SET_CONFIG = 1'b1; MAX_TRIGGER_LENGTH = 16'd16;
    cycle();
    SET_CONFIG = 1'b0;

    // 5: random backpressure, ch0..2, pointer 0 -> order 1,2,0,1,2,0
    rand_rdy = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 3; c++) load_frame(c, 50 + f, 3 + 2*c + f, 8'hAA);
    for (int f = 0; f < 2; f++) begin
      exp_frame(1, 50 + f, 5 + f, 16);
      exp_frame(2, 50 + f, 7 + f, 16);
      exp_frame(0, 50 + f, 3 + f, 16);
    end
    drain("t5", 1000);
    rand_rdy = 1'b0;
    M_AXIS_tready = 1'b1;
    chk("t5_drop", 64'(DROP_COUNT), 64'd3);

    // 6: config window opens mid-frame on ch2; ch3 must wait for it to close
    ch3_start = src_wr[3];
    load_frame(2, 60, 6, 8'hAA); exp_frame(2, 60, 6, 16);
    load_frame(3, 61, 2, 8'hAA); exp_frame(3, 61, 2, 16);
    repeat (4) cycle();
    chk("t6_busy_mid", 64'(BUSY), 64'd1);
    SET_CONFIG = 1'b1;
    for (int i = 0; i < 100 && !(src_rd[2] == src_wr[2] && BUSY == 1'b0); i++) cycle();
    repeat (8) cycle();
    chk("t6_ch2_done", 64'(src_rd[2]), 64'(src_wr[2]));
    chk("t6_idle_cfg", 64'(BUSY), 64'd0);
    chk("t6_ch3_held", 64'(src_rd[3]), 64'(ch3_start));
    chk("t6_exp_left", 64'(exp_q.size()), 64'd4);
    SET_CONFIG = 1'b0;
    drain("t6", 200);
    chk("t6_grant", 64'(GRANT_ID), 64'd3);
    chk("t6_drop", 64'(DROP_COUNT), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
